gate_seq_ctrl: RTL and testbench

Sequencer that exercises the two-input gate unit (AND/OR/NOT) on-board: it drives the gate inputs through all four combinations of A/B, waits a programmable settle time, samples the three gate outputs, and checks them against the expected truth table. A single start/done handshake runs the whole sweep and returns a pass flag and a per-vector failure mask. It sits between the board's control logic (buttons/switches) and the gate unit's inputs and outputs.

---
 rtl/gate_seq_ctrl_if.sv | 43 ++++
 rtl/gate_seq_ctrl.sv | 177 +++++++++++++++++
 tb/tb_gate_seq_ctrl.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/gate_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// gate_seq_ctrl_if
//
// Purpose : Bundles the sweep handshake and the gate-unit connections of
//           gate_seq_ctrl into one interface.
//
// Signals :
//   iStart    control -> sequencer  start request (level-sampled in IDLE)
//   iAbort    control -> sequencer  abort request (acts in SETTLE/CHECK)
//   iAnd      gate    -> sequencer  AND output of the gate unit
//   iOr       gate    -> sequencer  OR output of the gate unit
//   iNot      gate    -> sequencer  NOT output of the gate unit (NOT of A)
//   oA, oB    sequencer -> gate     gate unit inputs A and B
//   oBusy     sequencer -> control  sweep in progress
//   oDone     sequencer -> control  one-cycle completion pulse
//   oPass     sequencer -> control  all checked vectors matched
//   oFailMask sequencer -> control  bit v set = vector v mismatched
//
// Modports: master = board control / gate unit side, slave = sequencer.
// -----------------------------------------------------------------------------
interface gate_seq_ctrl_if;
    logic       iStart;
    logic       iAbort;
    logic       iAnd;
    logic       iOr;
    logic       iNot;
    logic       oA;
    logic       oB;
    logic       oBusy;
    logic       oDone;
    logic       oPass;
    logic [3:0] oFailMask;

    modport master (
        output iStart, iAbort, iAnd, iOr, iNot,
        input  oA, oB, oBusy, oDone, oPass, oFailMask
    );

    modport slave (
        input  iStart, iAbort, iAnd, iOr, iNot,
        output oA, oB, oBusy, oDone, oPass, oFailMask
    );
endinterface

// File: rtl/gate_seq_ctrl.sv
// -----------------------------------------------------------------------------
// gate_seq_ctrl
//
// Purpose : On-board self-test sequencer for the two-input gate unit
//           (AND/OR/NOT). One start request sweeps A/B through 00,01,10,11,
//           lets each vector settle for HOLD_CYCLES cycles, samples the three
//           gate outputs in a CHECK cycle and records mismatches in a
//           per-vector fail mask. The sweep ends with a one-cycle done pulse
//           and a pass flag.
//
// Parameters:
//   HOLD_CYCLES  settle cycles per vector before sampling (legal 1..255)
//
// Ports:
//   iClk   in  clock, rising edge
//   iRst   in  asynchronous, active-high reset
//   bus    gate_seq_ctrl_if.slave (handshake + gate unit connections)
//
// Build option:
//   GATE_SEQ_STOP_ON_FAIL_EN  when defined, the first mismatching vector ends
//                             the sweep immediately (straight to DONE).
//
// All outputs are registered; every output update happens on the edge that
// changes state, so oA/oB only move on SETTLE entry (and back to 0 on IDLE
// entry) and stay stable through the CHECK cycle.
// -----------------------------------------------------------------------------
module gate_seq_ctrl #(
    parameter int unsigned HOLD_CYCLES = 2
) (
    input  logic          iClk,
    input  logic          iRst,
    gate_seq_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CHECK,
        DONE
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

`ifdef GATE_SEQ_STOP_ON_FAIL_EN
    localparam bit STOP_ON_FAIL = 1'b1;
`else
    localparam bit STOP_ON_FAIL = 1'b0;
`endif

    state_t     state, state_nxt;
    logic [1:0] vec, vec_nxt;
    logic [1:0] vec_inc;
    logic [7:0] hold_cnt, hold_cnt_nxt;
    logic       a_nxt, b_nxt;
    logic       busy_nxt, done_nxt, pass_nxt;
    logic [3:0] mask_nxt;
    logic       mismatch;
    logic [3:0] mask_upd;

    assign vec_inc = vec + 2'd1;

    // Expected truth table is evaluated on the vector currently driven onto
    // the gate unit, which is held stable through CHECK.
    always_comb begin
        mismatch = (bus.iAnd != (bus.oA & bus.oB)) ||
                   (bus.iOr  != (bus.oA | bus.oB)) ||
                   (bus.iNot != ~bus.oA);
        mask_upd      = bus.oFailMask;
        mask_upd[vec] = mismatch;
    end

    // Next-state and next-output logic.
    // NOTE: every signal gets its hold/default value first, so no path through
    // the case statement leaves one unassigned and no latch is inferred.
    always_comb begin
        state_nxt    = state;
        vec_nxt      = vec;
        hold_cnt_nxt = hold_cnt;
        a_nxt        = bus.oA;
        b_nxt        = bus.oB;
        busy_nxt     = bus.oBusy;
        done_nxt     = 1'b0;
        pass_nxt     = bus.oPass;
        mask_nxt     = bus.oFailMask;

        unique case (state)
            IDLE: begin
                if (bus.iStart) begin
                    state_nxt    = SETTLE;
                    vec_nxt      = 2'd0;
                    hold_cnt_nxt = 8'd0;
                    a_nxt        = 1'b0;
                    b_nxt        = 1'b0;
                    busy_nxt     = 1'b1;
                    pass_nxt     = 1'b0;
                    mask_nxt     = 4'b0000;
                end
            end

            SETTLE: begin
                if (hold_cnt == HOLD_LAST) begin
                    state_nxt    = CHECK;
                    hold_cnt_nxt = 8'd0;
                end else begin
                    hold_cnt_nxt = hold_cnt + 8'd1;
                end
            end

            CHECK: begin
                mask_nxt = mask_upd;
                if (vec == 2'd3 || (STOP_ON_FAIL && mismatch)) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = SETTLE;
                    vec_nxt   = vec_inc;
                    a_nxt     = vec_inc[1];
                    b_nxt     = vec_inc[0];
                end
            end

            DONE: begin
                state_nxt = IDLE;
                done_nxt  = 1'b1;
                pass_nxt  = (bus.oFailMask == 4'b0000);
                busy_nxt  = 1'b0;
                a_nxt     = 1'b0;
                b_nxt     = 1'b0;
                vec_nxt   = 2'd0;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Abort overrides everything above, including the CHECK mask update;
        // bits collected by earlier CHECK cycles are kept.
        if (bus.iAbort && (state == SETTLE || state == CHECK)) begin
            state_nxt    = IDLE;
            vec_nxt      = 2'd0;
            hold_cnt_nxt = 8'd0;
            a_nxt        = 1'b0;
            b_nxt        = 1'b0;
            busy_nxt     = 1'b0;
            done_nxt     = 1'b0;
            pass_nxt     = 1'b0;
            mask_nxt     = bus.oFailMask;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state         <= IDLE;
            vec           <= 2'd0;
            hold_cnt      <= 8'd0;
            bus.oA        <= 1'b0;
            bus.oB        <= 1'b0;
            bus.oBusy     <= 1'b0;
            bus.oDone     <= 1'b0;
            bus.oPass     <= 1'b0;
            bus.oFailMask <= 4'b0000;
        end else begin
            state         <= state_nxt;
            vec           <= vec_nxt;
            hold_cnt      <= hold_cnt_nxt;
            bus.oA        <= a_nxt;
            bus.oB        <= b_nxt;
            bus.oBusy     <= busy_nxt;
            bus.oDone     <= done_nxt;
            bus.oPass     <= pass_nxt;
            bus.oFailMask <= mask_nxt;
        end
    end

endmodule

// File: tb/tb_gate_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_gate_seq_ctrl
//
// Two sequencers share clock and reset: dut1 (HOLD_CYCLES=2) sees a gate-unit
// model with selectable stuck-at faults; dut2 (HOLD_CYCLES=1) sees a correct
// gate unit and is used for back-to-back sweeps with iStart held high.
// Expected completion results (done cycle, pass, mask) are queued when a sweep
// is started; monitors pop and compare whenever oDone is seen.
// -----------------------------------------------------------------------------
module tb_gate_seq_ctrl;

    typedef enum int {F_NONE, F_AND0, F_NOT1} fault_t;

    typedef struct {
        int         cyc;
        logic       pass;
        logic [3:0] mask;
    } exp_t;

    logic   clk;
    logic   rst;
    int     cyc;
    fault_t fault;
    int     n_checks;
    int     n_pass;
    exp_t   q1[$];
    exp_t   q2[$];

    gate_seq_ctrl_if b1 ();
    gate_seq_ctrl_if b2 ();

    gate_seq_ctrl #(.HOLD_CYCLES(2)) dut1 (.iClk(clk), .iRst(rst), .bus(b1));
    gate_seq_ctrl #(.HOLD_CYCLES(1)) dut2 (.iClk(clk), .iRst(rst), .bus(b2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Gate unit models.
    always_comb begin
        b1.iAnd = b1.oA & b1.oB;
        b1.iOr  = b1.oA | b1.oB;
        b1.iNot = ~b1.oA;
        if (fault == F_AND0) b1.iAnd = 1'b0;
        if (fault == F_NOT1) b1.iNot = 1'b1;
    end

    always_comb begin
        b2.iAnd = b2.oA & b2.oB;
        b2.iOr  = b2.oA | b2.oB;
        b2.iNot = ~b2.oA;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitors: compare completion results against the queued expectations.
    always @(negedge clk) begin
        if (!rst && b1.oDone === 1'b1) begin
            if (q1.size() == 0) begin
                check("dut1_spurious_done", b1.oDone, 1'b0);
            end else begin
                exp_t e;
                e = q1.pop_front();
                check("dut1_done_cycle", cyc, e.cyc);
                check("dut1_pass", b1.oPass, e.pass);
                check("dut1_mask", b1.oFailMask, e.mask);
                check("dut1_busy_at_done", b1.oBusy, 1'b0);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && b2.oDone === 1'b1) begin
            if (q2.size() == 0) begin
                check("dut2_spurious_done", b2.oDone, 1'b0);
            end else begin
                exp_t e;
                e = q2.pop_front();
                check("dut2_done_cycle", cyc, e.cyc);
                check("dut2_pass", b2.oPass, e.pass);
                check("dut2_mask", b2.oFailMask, e.mask);
            end
        end
    end

    // Called at a negedge: pulses iStart so the next posedge is "edge 0" and
    // queues the expected result for oDone seen after edge done_ofs.
    task automatic start_sweep1(input logic pass, input logic [3:0] mask,
                                input int done_ofs, input bit check_seq);
        exp_t e;
        e.cyc  = cyc + 1 + done_ofs;
        e.pass = pass;
        e.mask = mask;
        q1.push_back(e);
        b1.iStart = 1'b1;
        @(negedge clk);
        b1.iStart = 1'b0;
        if (check_seq) begin
            check("busy_after_start", b1.oBusy, 1'b1);
            for (int k = 0; k < 12; k++) begin
                logic [1:0] v;
                v = 2'(k / 3);
                check($sformatf("vector_seq_e%0d", k), {b1.oA, b1.oB}, v);
                @(negedge clk);
            end
        end
    endtask

    task automatic drain1();
        int budget;
        budget = 100;
        while (q1.size() != 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("dut1_drain", q1.size(), 0);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        fault     = F_NONE;
        rst       = 1'b1;
        b1.iStart = 1'b0;
        b1.iAbort = 1'b0;
        b2.iStart = 1'b0;
        b2.iAbort = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {b1.oA, b1.oB, b1.oBusy, b1.oDone, b1.oPass, b1.oFailMask}, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_outputs", {b1.oA, b1.oB, b1.oBusy, b1.oDone}, 0);

        // Clean sweep with vector sequence check.
        start_sweep1(1'b1, 4'b0000, 13, 1'b1);
        drain1();
        check("idle_ab_after_done", {b1.oA, b1.oB}, 2'b00);

        // AND stuck at 0: only vector 3 fails; same timing in both builds.
        fault = F_AND0;
        start_sweep1(1'b0, 4'b1000, 13, 1'b0);
        drain1();
        check("mask_holds_after_done", b1.oFailMask, 4'b1000);

        // NOT stuck at 1: vectors 2 and 3 fail.
        fault = F_NOT1;
`ifdef GATE_SEQ_STOP_ON_FAIL_EN
        start_sweep1(1'b0, 4'b0100, 10, 1'b0);
`else
        start_sweep1(1'b0, 4'b1100, 13, 1'b0);
`endif
        drain1();
        fault = F_NONE;

        // Abort in the second SETTLE cycle of vector 1 (after edge 4).
        b1.iStart = 1'b1;
        @(negedge clk);
        b1.iStart = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_pre_vector", {b1.oA, b1.oB}, 2'b01);
        b1.iAbort = 1'b1;
        @(negedge clk);
        b1.iAbort = 1'b0;
        check("abort_busy", b1.oBusy, 1'b0);
        check("abort_pass", b1.oPass, 1'b0);
        check("abort_mask", b1.oFailMask, 4'b0000);
        check("abort_ab", {b1.oA, b1.oB}, 2'b00);
        repeat (20) @(negedge clk);
        start_sweep1(1'b1, 4'b0000, 13, 1'b0);
        drain1();

        // Asynchronous reset between edges during vector 2.
        b1.iStart = 1'b1;
        @(negedge clk);
        b1.iStart = 1'b0;
        repeat (6) @(negedge clk);
        check("pre_reset_vector", {b1.oA, b1.oB, b1.oBusy}, 3'b101);
        #2 rst = 1'b1;
        #1 check("async_reset_outputs",
                 {b1.oA, b1.oB, b1.oBusy, b1.oDone, b1.oPass, b1.oFailMask}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        start_sweep1(1'b1, 4'b0000, 13, 1'b1);
        drain1();

        // Back-to-back sweeps on dut2 (HOLD_CYCLES=1): done every 10 cycles.
        begin
            int base;
            int budget;
            base = cyc + 1;
            for (int s = 0; s < 3; s++) begin
                exp_t e;
                e.cyc  = base + 9 + 10 * s;
                e.pass = 1'b1;
                e.mask = 4'b0000;
                q2.push_back(e);
            end
            b2.iStart = 1'b1;
            repeat (22) @(negedge clk);
            check("dut2_busy_third_sweep", b2.oBusy, 1'b1);
            b2.iStart = 1'b0;
            budget = 100;
            while (q2.size() != 0 && budget > 0) begin
                @(negedge clk);
                budget--;
            end
            check("dut2_drain", q2.size(), 0);
            repeat (15) @(negedge clk);
            check("dut2_idle_after_release", b2.oBusy, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
